// File: rtl/alu_cmd_master.sv
// alu_cmd_master
//   Host-side command initiator for the UART-attached ALU. Takes one
//   (A, B, opcode) request, sends it as three bytes through a UART
//   transmitter (A, B, then the zero-padded opcode), waits for the single
//   result byte from a UART receiver and presents it as a one-cycle response.
//
// Optional feature (compile-time macro):
//   ALU_CMD_MASTER_TIMEOUT_EN - bound the result wait to TIMEOUT_CYCLES;
//   when undefined, o_timeout is tied low and the result wait is unbounded.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_req_valid         request present
//   o_req_ready         idle, request can be accepted
//   i_a, i_b, i_opcode  request operands / opcode, captured on accept
//   o_tx_start, o_tx    one-cycle start pulse and byte to the transmitter
//   i_tx_done           transmitter idle (high) / sending (low)
//   i_rx_done, i_rx     one-cycle received-byte pulse and data
//   o_resp_valid        one-cycle pulse, o_result just updated
//   o_result            last received result byte
//   o_busy              transaction in progress
//   o_timeout           one-cycle pulse, result wait aborted
//   dbg_state           current FSM state, for debug and checkers
//
// Request handshake: a request transfers on a rising edge where i_req_valid
// and o_req_ready are both high. o_req_ready depends only on registered
// state, never on i_req_valid, and the operands are sampled on that edge only.

module alu_cmd_master #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_opcode,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx,
  input  logic               i_tx_done,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx,
  output logic               o_resp_valid,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [2:0]         dbg_state
);

  if (NB_OP > NB_DATA || NB_OP < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("alu_cmd_master: need 1 <= NB_OP <= NB_DATA and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    TXBUSY = 3'd2,
    TXWAIT = 3'd3,
    RXWAIT = 3'd4
  } state_t;

  state_t             state;
  logic [1:0]         byte_idx;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_DATA-1:0] op_q;
  logic [NB_DATA-1:0] cur_byte;

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  assign wait_cnt_next = wait_cnt + 1'b1;
`else
  assign o_timeout = 1'b0;
`endif

  // Wire order: index 0 = A, 1 = B, 2 = zero-padded opcode.
  always_comb begin
    cur_byte = op_q;
    case (byte_idx)
      2'd0:    cur_byte = a_q;
      2'd1:    cur_byte = b_q;
      default: cur_byte = op_q;
    endcase
  end

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      o_tx_start   <= 1'b0;
      o_tx         <= '0;
      o_resp_valid <= 1'b0;
      o_result     <= '0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
      wait_cnt     <= '0;
      o_timeout    <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      o_tx_start   <= 1'b0;
      o_resp_valid <= 1'b0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
      o_timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            a_q      <= i_a;
            b_q      <= i_b;
            op_q     <= NB_DATA'(i_opcode);
            byte_idx <= 2'd0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_tx_done) begin
            o_tx_start <= 1'b1;
            o_tx       <= cur_byte;
            state      <= TXBUSY;
          end
        end
        TXBUSY: begin
          // Wait for the transmitter to acknowledge the start by going busy.
          if (!i_tx_done) begin
            state <= TXWAIT;
          end
        end
        TXWAIT: begin
          // Receive pulses here are dropped, even one coinciding with the
          // final byte completing; the result wait starts only after this.
          if (i_tx_done) begin
            if (byte_idx == 2'd2) begin
              state <= RXWAIT;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= SEND;
            end
          end
        end
        RXWAIT: begin
          if (i_rx_done) begin
            o_result     <= i_rx;
            o_resp_valid <= 1'b1;
            state        <= IDLE;
          end
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
          // The count reaching TIMEOUT_CYCLES on this edge aborts the wait,
          // so o_timeout appears TIMEOUT_CYCLES cycles after RXWAIT entry.
          // A result arriving on the same edge takes priority above.
          else if (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES)) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
module tb_alu_cmd_master;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic [5:0] i_opcode;
  logic       o_tx_start;
  logic [7:0] o_tx;
  logic       i_tx_done;
  logic       i_rx_done;
  logic [7:0] i_rx;
  logic       o_resp_valid;
  logic [7:0] o_result;
  logic       o_busy;
  logic       o_timeout;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  alu_cmd_master #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_a(i_a),
    .i_b(i_b),
    .i_opcode(i_opcode),
    .o_tx_start(o_tx_start),
    .o_tx(o_tx),
    .i_tx_done(i_tx_done),
    .i_rx_done(i_rx_done),
    .i_rx(i_rx),
    .o_resp_valid(o_resp_valid),
    .o_result(o_result),
    .o_busy(o_busy),
    .o_timeout(o_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];      // bytes the transmitter must still see, in order
  logic [7:0] last_result;   // what o_result must hold between responses
  int         exp_resp = 0;
  int         resp_seen = 0;
  int         exp_timeouts = 0;
  int         timeout_seen = 0;
  int         start_seen = 0;
  bit         tx_force_low = 1'b0;
  bit         tx_fixed = 1'b1;

  function automatic void chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model of the wire format: A, B, then opcode zero-extended.
  function automatic logic [23:0] wire_bytes(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
    logic [7:0] op_byte;
    op_byte = {2'b00, op};
    return {a, b, op_byte};
  endfunction

  // ---------------- transmitter model + byte scoreboard ----------------
  // Outputs are read 1 time unit after the edge; i_tx_done is driven 2 units
  // after the edge, so the bench's own readers never race with it.
  initial begin : tx_model
    bit pend;
    int cnt;
    pend = 1'b0;
    cnt = 0;
    i_tx_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (o_tx_start) begin
        start_seen++;
        chkb("start_only_when_tx_idle", i_tx_done, 1'b1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start: got byte 0x%02h expected no start (t=%0t)", o_tx, $time);
        end else begin
          chk8("tx_byte", o_tx, exp_q.pop_front());
        end
        pend = 1'b1;
      end
      #1;
      if (tx_force_low) begin
        i_tx_done = 1'b0;
      end else if (pend) begin
        pend = 1'b0;
        cnt = tx_fixed ? 10 : $urandom_range(1, 12);
        i_tx_done = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) i_tx_done = 1'b1;
      end else begin
        i_tx_done = 1'b1;
      end
    end
  end

  // Pulse counters for end-of-run totals.
  initial begin : pulse_mon
    forever begin
      @(posedge clk);
      #1;
      if (o_resp_valid) resp_seen++;
      if (o_timeout) timeout_seen++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish expected finish within 600000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chkb("rst_req_ready", o_req_ready, 1'b1);
    chkb("rst_tx_start", o_tx_start, 1'b0);
    chk8("rst_tx", o_tx, 8'h00);
    chkb("rst_resp_valid", o_resp_valid, 1'b0);
    chk8("rst_result", o_result, 8'h00);
    chkb("rst_busy", o_busy, 1'b0);
    chkb("rst_timeout", o_timeout, 1'b0);
  endtask

  // Issues one request and follows it through the first start pulse; a
  // held-busy transmitter at accept and a stray receive pulse during byte B
  // are optional.
  task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          input bit busy, input bit stray,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    int budget;
    bit early;
    budget = 0;
    while (!o_req_ready && budget < 500) begin step(); budget++; end
    chkb("ready_before_req", o_req_ready, 1'b1);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    if (busy) tx_force_low = 1'b1;
    i_req_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_opcode = op;
    step();
    // Scramble the inputs: the captured request must not follow them.
    i_req_valid = 1'b0;
    i_a = 8'($urandom);
    i_b = 8'($urandom);
    i_opcode = 6'($urandom);
    chkb("busy_after_accept", o_busy, 1'b1);
    chkb("not_ready_after_accept", o_req_ready, 1'b0);
    if (busy) begin
      early = 1'b0;
      repeat (5) begin
        step();
        if (o_tx_start) early = 1'b1;
      end
      chkb("no_start_while_tx_held", early, 1'b0);
      tx_force_low = 1'b0;
      step();
      chkb("start_1_after_release", o_tx_start, 1'b1);
    end else begin
      step();
      chkb("start_cycle_after_accept", o_tx_start, 1'b1);
    end
    if (stray) begin
      budget = 0;
      while (!(exp_q.size() <= 1 && !i_tx_done) && budget < 200) begin step(); budget++; end
      chkb("byte_b_in_flight", (exp_q.size() <= 1 && !i_tx_done), 1'b1);
      i_rx_done = 1'b1;
      i_rx = 8'h55;
      step();
      i_rx_done = 1'b0;
      chkb("stray_no_resp", o_resp_valid, 1'b0);
      chk8("stray_result_kept", o_result, last_result);
      chkb("stray_still_busy", o_busy, 1'b1);
    end
  endtask

  // Returns at the first sample point after the DUT has seen the third byte
  // finish, i.e. one sample after the edge on which the result wait begins.
  task automatic wait_bytes_done();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 1000) begin step(); budget++; end
    chki("all_bytes_sent", exp_q.size(), 0);
    budget = 0;
    while (i_tx_done && budget < 100) begin step(); budget++; end
    budget = 0;
    while (!i_tx_done && budget < 100) begin step(); budget++; end
    chkb("last_byte_complete", i_tx_done, 1'b1);
  endtask

  task automatic reply(input logic [7:0] rsp);
    repeat ($urandom_range(0, 3)) step();
    i_rx_done = 1'b1;
    i_rx = rsp;
    step();
    i_rx_done = 1'b0;
    i_rx = 8'($urandom);
    chkb("resp_valid", o_resp_valid, 1'b1);
    chk8("result", o_result, rsp);
    chkb("ready_with_resp", o_req_ready, 1'b1);
    chkb("not_busy_with_resp", o_busy, 1'b0);
    last_result = rsp;
    exp_resp++;
    step();
    chkb("resp_one_cycle", o_resp_valid, 1'b0);
    chk8("result_held", o_result, rsp);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] rsp;
    bit         busy;
    bit         stray;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int         budget;
    int         s0;
    bit         flag;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [5:0] rop;
    logic [23:0] w;

    vecs[0] = '{a:8'd10, b:8'd20, op:6'h20, rsp:8'h1E, busy:0, stray:0, e0:8'h0A, e1:8'h14, e2:8'h20};
    vecs[1] = '{a:8'd10, b:8'd20, op:6'h20, rsp:8'h1E, busy:1, stray:0, e0:8'h0A, e1:8'h14, e2:8'h20};
    vecs[2] = '{a:8'd10, b:8'd20, op:6'h20, rsp:8'h1E, busy:0, stray:1, e0:8'h0A, e1:8'h14, e2:8'h20};
    vecs[3] = '{a:8'hFF, b:8'h00, op:6'h3F, rsp:8'hA5, busy:0, stray:0, e0:8'hFF, e1:8'h00, e2:8'h3F};
    vecs[4] = '{a:8'h00, b:8'hFF, op:6'h00, rsp:8'h80, busy:0, stray:0, e0:8'h00, e1:8'hFF, e2:8'h00};
    vecs[5] = '{a:8'h5A, b:8'hC3, op:6'h15, rsp:8'h7E, busy:1, stray:1, e0:8'h5A, e1:8'hC3, e2:8'h15};

    rst = 1'b0;
    i_req_valid = 1'b0;
    i_a = 8'h00;
    i_b = 8'h00;
    i_opcode = 6'h00;
    i_rx_done = 1'b0;
    i_rx = 8'h00;
    last_result = 8'h00;

    repeat (2) step();
    check_reset_vals();
    rst = 1'b1;
    step();
    chkb("ready_after_reset", o_req_ready, 1'b1);

    // Directed table: fixed 10-cycle transmitter.
    tx_fixed = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].busy, vecs[i].stray,
               vecs[i].e0, vecs[i].e1, vecs[i].e2);
      wait_bytes_done();
      reply(vecs[i].rsp);
    end

    // Reset while byte B is in flight: no opcode byte may follow.
    send_req(8'h11, 8'h22, 6'h03, 1'b0, 1'b0, 8'h11, 8'h22, 8'h03);
    budget = 0;
    while (!(exp_q.size() <= 1 && !i_tx_done) && budget < 200) begin step(); budget++; end
    chkb("reset_window_found", (exp_q.size() <= 1 && !i_tx_done), 1'b1);
    rst = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    last_result = 8'h00;
    s0 = start_seen;
    step();
    step();
    rst = 1'b1;
    repeat (30) step();
    chki("no_start_after_reset", start_seen - s0, 0);
    chkb("ready_after_mid_reset", o_req_ready, 1'b1);
    chkb("idle_after_mid_reset", o_busy, 1'b0);

    // Result wait with no reply.
    send_req(8'h33, 8'h44, 6'h01, 1'b0, 1'b0, 8'h33, 8'h44, 8'h01);
    wait_bytes_done();
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    flag = 1'b0;
    repeat (49) begin
      step();
      if (o_timeout || !o_busy) flag = 1'b1;
    end
    chkb("no_early_timeout", flag, 1'b0);
    step();
    chkb("timeout_at_50", o_timeout, 1'b1);
    chk8("timeout_result_kept", o_result, last_result);
    chkb("timeout_no_resp", o_resp_valid, 1'b0);
    chkb("ready_after_timeout", o_req_ready, 1'b1);
    exp_timeouts++;
    step();
    chkb("timeout_one_cycle", o_timeout, 1'b0);
    send_req(8'h66, 8'h77, 6'h2A, 1'b0, 1'b0, 8'h66, 8'h77, 8'h2A);
    wait_bytes_done();
    reply(8'h3C);
`else
    flag = 1'b0;
    repeat (120) begin
      step();
      if (o_timeout || !o_busy) flag = 1'b1;
    end
    chkb("waits_without_timeout", flag, 1'b0);
    reply(8'h3C);
`endif

    // Randomized transactions against the wire-format model.
    tx_fixed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = 6'($urandom);
      w = wire_bytes(ra, rb, rop);
      send_req(ra, rb, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               w[23:16], w[15:8], w[7:0]);
      wait_bytes_done();
      reply(8'($urandom));
    end

    repeat (5) step();
    chki("resp_pulse_count", resp_seen, exp_resp);
    chki("timeout_pulse_count", timeout_seen, exp_timeouts);
    chki("leftover_bytes", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
